hub75_scan_driver: RTL and testbench

Scan driver for the 64x64 HUB75 LED matrix (two 32-line halves, 1-bit colour per channel). It generates `line`/`column` addresses for a combinational pixel source (pattern ROMs and similar), samples the returned r1/g1/b1/r2/g2/b2 bits, and shifts them into the panel. It also produces the latch, output-enable and row-address sequence. It sits between the pattern source and the top-level panel pins.

---
 rtl/hub75_scan_driver.sv | 209 ++++++++++++++++++++
 tb/tb_hub75_scan_driver.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan_driver.sv
// hub75_scan_driver
// Scan driver for a 64x64 HUB75 panel built from two 32-line halves with
// 1-bit colour per channel. It walks a combinational pixel source through
// line/column addresses, registers the returned bits onto the panel data
// pins, and sequences the shift clock, blanking, latch and row address.
//
// Optional build macro: HUB75_OE_DIM_EN adds the 3-bit `dim` input, which
// shortens the lit part of each line to the first 64 - 8*dim columns.
//
// Ports
//   sys_clk, sys_rst_n        system clock, asynchronous active-low reset
//   enable                    run scanning; a line in progress always completes
//   dim (HUB75_OE_DIM_EN)     brightness step, sampled in the latch cycle
//   pix_line, pix_column      registered address to the pixel source
//   pix_r1..pix_b2            pixel bits, combinational from the address
//   hub_r1..hub_b2            registered panel data
//   hub_clk                   panel shift clock (panel samples on rising edge)
//   hub_lat                   panel latch, active high
//   hub_oe_n                  panel output enable, active low
//   hub_addr                  panel row address A..E
//   frame_done                one-cycle pulse in the latch cycle of line 31
//
// state | meaning
// IDLE  | not scanning, panel dark, waits for enable
// SHIFT | shifting the 64 columns of pix_line; previous row stays lit
// BLANK | panel dark for BLANK_CYCLES ahead of the latch
// LATCH | one cycle: latch the shifted row, advance the line counter

module hub75_scan_driver #(
  parameter int CLK_DIV      = 2,
  parameter int BLANK_CYCLES = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       enable,
`ifdef HUB75_OE_DIM_EN
  input  logic [2:0] dim,
`endif
  output logic [4:0] pix_line,
  output logic [5:0] pix_column,
  input  logic       pix_r1,
  input  logic       pix_g1,
  input  logic       pix_b1,
  input  logic       pix_r2,
  input  logic       pix_g2,
  input  logic       pix_b2,
  output logic       hub_r1,
  output logic       hub_g1,
  output logic       hub_b1,
  output logic       hub_r2,
  output logic       hub_g2,
  output logic       hub_b2,
  output logic       hub_clk,
  output logic       hub_lat,
  output logic       hub_oe_n,
  output logic [4:0] hub_addr,
  output logic       frame_done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;
  localparam logic [1:0] ST_LATCH = 2'd3;

  localparam int PH_W = $clog2(2 * CLK_DIV);
  localparam int BL_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  // Phase counter runs down; PH_TOP is the first cycle of a column (load
  // data, clock low), PH_RISE is where the clock goes high, zero is the last.
  localparam logic [PH_W-1:0] PH_TOP  = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_RISE = PH_W'(CLK_DIV - 1);
  localparam logic [BL_W-1:0] BL_TOP  = BL_W'(BLANK_CYCLES - 1);

  logic [1:0]      state, state_nx;
  logic [PH_W-1:0] ph_cnt, ph_nx;
  logic [BL_W-1:0] bl_cnt, bl_nx;
  logic            shown_valid, shown_nx;
  logic [4:0]      line_nx;
  logic [5:0]      column_nx;
  logic [5:0]      hub_rgb, rgb_nx;
  logic            clk_nx, lat_nx, oe_nx, done_nx;
  logic [4:0]      addr_nx;
  logic [6:0]      on_limit_nx;

  assign {hub_b2, hub_g2, hub_r2, hub_b1, hub_g1, hub_r1} = hub_rgb;

  always_comb begin
    state_nx  = state;
    ph_nx     = ph_cnt;
    bl_nx     = bl_cnt;
    shown_nx  = shown_valid;
    line_nx   = pix_line;
    column_nx = pix_column;
    rgb_nx    = hub_rgb;
    clk_nx    = hub_clk;
    lat_nx    = 1'b0;
    addr_nx   = hub_addr;
    done_nx   = 1'b0;
    case (state)
      ST_IDLE: begin
        // The line counter is kept so a restart continues where it stopped.
        shown_nx  = 1'b0;
        column_nx = 6'd0;
        clk_nx    = 1'b0;
        if (enable) begin
          state_nx = ST_SHIFT;
          ph_nx    = PH_TOP;
        end
      end
      ST_SHIFT: begin
        if (ph_cnt == PH_TOP) begin
          clk_nx = 1'b0;
          rgb_nx = {pix_b2, pix_g2, pix_r2, pix_b1, pix_g1, pix_r1};
        end
        if (ph_cnt == PH_RISE) begin
          clk_nx = 1'b1;
        end
        if (ph_cnt == '0) begin
          ph_nx     = PH_TOP;
          column_nx = pix_column + 6'd1;
          if (pix_column == 6'd63) begin
            // Column 63's high phase ends in the first BLANK cycle, exactly
            // as every other column's ends in the next column's first cycle.
            state_nx = ST_BLANK;
            bl_nx    = BL_TOP;
          end
        end else begin
          ph_nx = ph_cnt - 1'b1;
        end
      end
      ST_BLANK: begin
        clk_nx = 1'b0;
        if (bl_cnt == '0) begin
          state_nx = ST_LATCH;
          lat_nx   = 1'b1;
          addr_nx  = pix_line;
          done_nx  = (pix_line == 5'd31);
        end else begin
          bl_nx = bl_cnt - 1'b1;
        end
      end
      ST_LATCH: begin
        shown_nx = 1'b1;
        line_nx  = pix_line + 5'd1;
        ph_nx    = PH_TOP;
        state_nx = enable ? ST_SHIFT : ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

`ifdef HUB75_OE_DIM_EN
  logic [2:0] dim_q, dim_nx;

  always_comb begin
    dim_nx = (state == ST_LATCH) ? dim : dim_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dim_q <= 3'd0;
    end else begin
      dim_q <= dim_nx;
    end
  end

  assign on_limit_nx = 7'd64 - {1'b0, dim_nx, 3'b000};
`else
  assign on_limit_nx = 7'd64;
`endif

  // Output enable is registered from the next-cycle state so it is exact for
  // every cycle of SHIFT, and always high in BLANK/LATCH/IDLE.
  assign oe_nx = ~((state_nx == ST_SHIFT) && shown_nx &&
                   ({1'b0, column_nx} < on_limit_nx));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ST_IDLE;
      ph_cnt      <= '0;
      bl_cnt      <= '0;
      shown_valid <= 1'b0;
      pix_line    <= 5'd0;
      pix_column  <= 6'd0;
      hub_rgb     <= 6'd0;
      hub_clk     <= 1'b0;
      hub_lat     <= 1'b0;
      hub_oe_n    <= 1'b1;
      hub_addr    <= 5'd0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_nx;
      ph_cnt      <= ph_nx;
      bl_cnt      <= bl_nx;
      shown_valid <= shown_nx;
      pix_line    <= line_nx;
      pix_column  <= column_nx;
      hub_rgb     <= rgb_nx;
      hub_clk     <= clk_nx;
      hub_lat     <= lat_nx;
      hub_oe_n    <= oe_nx;
      hub_addr    <= addr_nx;
      frame_done  <= done_nx;
    end
  end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Testbench for hub75_scan_driver with CLK_DIV=1, BLANK_CYCLES=2.
// Expected behaviour comes from line-position arithmetic (a line is 128
// SHIFT cycles, 2 BLANK cycles and one LATCH cycle) and a pixel table.
// Define HUB75_OE_DIM_EN for both files to include the dimming scenario.

module tb_hub75_scan_driver;

  localparam int CD        = 1;
  localparam int BL        = 2;
  localparam int SHIFT_CYC = 128 * CD;
  localparam int L         = SHIFT_CYC + BL + 1;
  localparam logic [25:0] RST_VAL = 26'd64;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       enable = 1'b0;
`ifdef HUB75_OE_DIM_EN
  logic [2:0] dim = 3'd0;
`endif
  logic [4:0] pix_line;
  logic [5:0] pix_column;
  logic       pix_r1, pix_g1, pix_b1, pix_r2, pix_g2, pix_b2;
  logic       hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2;
  logic       hub_clk, hub_lat, hub_oe_n, frame_done;
  logic [4:0] hub_addr;

  logic [5:0] rom [0:2047];
  int         pat_mode = 0;
  logic [5:0] pix_bits, hub_bits;
  int         checks = 0;
  int         errors = 0;

  hub75_scan_driver #(.CLK_DIV(CD), .BLANK_CYCLES(BL)) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .enable(enable),
`ifdef HUB75_OE_DIM_EN
    .dim(dim),
`endif
    .pix_line(pix_line),
    .pix_column(pix_column),
    .pix_r1(pix_r1), .pix_g1(pix_g1), .pix_b1(pix_b1),
    .pix_r2(pix_r2), .pix_g2(pix_g2), .pix_b2(pix_b2),
    .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1),
    .hub_r2(hub_r2), .hub_g2(hub_g2), .hub_b2(hub_b2),
    .hub_clk(hub_clk),
    .hub_lat(hub_lat),
    .hub_oe_n(hub_oe_n),
    .hub_addr(hub_addr),
    .frame_done(frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  // Pixel source: mode 0 puts column bit 0 on r1 only, mode 1 reads a table.
  always_comb begin
    pix_bits = (pat_mode == 0) ? {5'b0, pix_column[0]} : rom[{pix_line, pix_column}];
  end
  assign {pix_b2, pix_g2, pix_r2, pix_b1, pix_g1, pix_r1} = pix_bits;
  assign hub_bits = {hub_b2, hub_g2, hub_r2, hub_b1, hub_g1, hub_r1};

  function automatic logic [5:0] pat(int ln, int col);
    if (pat_mode == 0) return {5'b0, col[0]};
    return rom[ln * 64 + col];
  endfunction

  function automatic logic [25:0] snap();
    return {pix_line, pix_column, hub_bits, hub_clk, hub_lat, hub_oe_n, hub_addr, frame_done};
  endfunction

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    enable    = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    enable    = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (snap() !== RST_VAL) begin
      errors++;
      $display("FAIL reset_values got %h want %h", snap(), RST_VAL);
    end
    sys_rst_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge sys_clk);
      checks++;
      if (snap() !== RST_VAL) begin
        errors++;
        $display("FAIL idle_hold cycle %0d got %h want %h", i, snap(), RST_VAL);
      end
    end
  endtask

  task automatic test_pattern();
    int k = 0, ln = 0, e = 0, lines = 0, sc = 0, guard = 0;
    logic pclk = 1'b0;
    logic [5:0] pdata = 6'd0;
    logic exp_oe;
    pat_mode = 0;
    do_reset();
    enable = 1'b1;
    while (lines < 3 && guard < 4 * L) begin
      @(negedge sys_clk);
      guard++;
      sc = (hub_bits !== pdata) ? 1 : sc + 1;
      if (hub_clk === 1'b1 && pclk === 1'b0) begin
        checks++;
        if (hub_bits !== pat(ln, e)) begin
          errors++;
          $display("FAIL pattern_data line %0d edge %0d got %h want %h", ln, e, hub_bits, pat(ln, e));
        end
        checks++;
        if (sc < CD + 1) begin
          errors++;
          $display("FAIL data_setup edge %0d got %0d want >=%0d", e, sc, CD + 1);
        end
        e++;
      end
      exp_oe = (k < SHIFT_CYC && lines > 0) ? 1'b0 : 1'b1;
      checks++;
      if (hub_oe_n !== exp_oe) begin
        errors++;
        $display("FAIL pattern_oe line %0d pos %0d got %b want %b", lines, k, hub_oe_n, exp_oe);
      end
      checks++;
      if (hub_lat !== (k == L - 1)) begin
        errors++;
        $display("FAIL pattern_lat pos %0d got %b want %b", k, hub_lat, (k == L - 1));
      end
      if (k == L - 1) begin
        checks++;
        if (e != 64) begin
          errors++;
          $display("FAIL clk_edges line %0d got %0d want 64", ln, e);
        end
        checks++;
        if (hub_addr !== 5'(ln)) begin
          errors++;
          $display("FAIL pattern_addr got %0d want %0d", hub_addr, ln);
        end
        checks++;
        if (hub_clk !== 1'b0) begin
          errors++;
          $display("FAIL lat_clk got %b want 0", hub_clk);
        end
        lines++;
        ln++;
        e = 0;
        k = 0;
      end else begin
        k++;
      end
      pclk  = hub_clk;
      pdata = hub_bits;
    end
    checks++;
    if (lines < 3) begin
      errors++;
      $display("FAIL pattern_timeout got %0d lines want 3", lines);
    end
  endtask

  task automatic test_frame();
    int k = 0, ln = 0, e = 0, cyc = 0, nfd = 0, last_fd = 0;
    logic pclk = 1'b0;
    logic [4:0] paddr = 5'd0;
    pat_mode = 1;
    do_reset();
    enable = 1'b1;
    while (nfd < 2 && cyc < 70 * L) begin
      @(negedge sys_clk);
      cyc++;
      if (hub_clk === 1'b1 && pclk === 1'b0) begin
        checks++;
        if (hub_bits !== pat(ln, e)) begin
          errors++;
          $display("FAIL frame_data line %0d edge %0d got %h want %h", ln, e, hub_bits, pat(ln, e));
        end
        e++;
      end
      checks++;
      if (frame_done !== (k == L - 1 && ln == 31)) begin
        errors++;
        $display("FAIL frame_done line %0d pos %0d got %b want %b", ln, k, frame_done, (k == L - 1 && ln == 31));
      end
      checks++;
      if (hub_addr !== paddr && hub_lat !== 1'b1) begin
        errors++;
        $display("FAIL addr_change_outside_lat got %0d want %0d", hub_addr, paddr);
      end
      if (frame_done === 1'b1) begin
        checks++;
        if (cyc - last_fd != 32 * L) begin
          errors++;
          $display("FAIL frame_period got %0d want %0d", cyc - last_fd, 32 * L);
        end
        nfd++;
        last_fd = cyc;
      end
      if (k == L - 1) begin
        checks++;
        if (hub_addr !== 5'(ln)) begin
          errors++;
          $display("FAIL frame_addr got %0d want %0d", hub_addr, ln);
        end
        ln = (ln + 1) % 32;
        e = 0;
        k = 0;
      end else begin
        k++;
      end
      pclk  = hub_clk;
      paddr = hub_addr;
    end
    checks++;
    if (nfd < 2) begin
      errors++;
      $display("FAIL frame_timeout got %0d pulses want 2", nfd);
    end
  endtask

  task automatic test_enable_drop();
    int k = 0, ln = 0, e = 0, idle_left = 0, guard = 0;
    bit shown = 0, resumed = 0, done = 0;
    logic pclk = 1'b0;
    logic exp_oe;
    pat_mode = 1;
    do_reset();
    enable = 1'b1;
    while (!done && guard < 12 * L) begin
      @(negedge sys_clk);
      guard++;
      if (idle_left > 0) begin
        checks++;
        if (hub_oe_n !== 1'b1 || hub_clk !== 1'b0 || hub_lat !== 1'b0 || hub_addr !== 5'd5) begin
          errors++;
          $display("FAIL idle_after_drop got oe %b clk %b lat %b addr %0d want 1 0 0 5",
                   hub_oe_n, hub_clk, hub_lat, hub_addr);
        end
        idle_left--;
        if (idle_left == 0) begin
          enable  = 1'b1;
          resumed = 1;
          k = 0;
        end
        pclk = hub_clk;
        continue;
      end
      if (ln == 5 && k == 40 * CD && !resumed) enable = 1'b0;
      if (hub_clk === 1'b1 && pclk === 1'b0) begin
        checks++;
        if (hub_bits !== pat(ln, e)) begin
          errors++;
          $display("FAIL drop_data line %0d edge %0d got %h want %h", ln, e, hub_bits, pat(ln, e));
        end
        e++;
      end
      exp_oe = (k < SHIFT_CYC && shown) ? 1'b0 : 1'b1;
      checks++;
      if (hub_oe_n !== exp_oe) begin
        errors++;
        $display("FAIL drop_oe line %0d pos %0d got %b want %b", ln, k, hub_oe_n, exp_oe);
      end
      checks++;
      if (hub_lat !== (k == L - 1)) begin
        errors++;
        $display("FAIL drop_lat line %0d pos %0d got %b want %b", ln, k, hub_lat, (k == L - 1));
      end
      if (k == L - 1) begin
        checks++;
        if (hub_addr !== 5'(ln)) begin
          errors++;
          $display("FAIL drop_addr got %0d want %0d", hub_addr, ln);
        end
        if (ln == 5 && !resumed) begin
          idle_left = 20;
          shown = 0;
        end else begin
          shown = 1;
        end
        if (ln == 7) done = 1;
        ln = (ln + 1) % 32;
        e = 0;
        k = 0;
      end else begin
        k++;
      end
      pclk = hub_clk;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drop_timeout got line %0d want 8", ln);
    end
    enable = 1'b0;
  endtask

  task automatic test_async_reset();
    pat_mode = 1;
    do_reset();
    enable = 1'b1;
    repeat (2 * L + 31) @(negedge sys_clk);
    checks++;
    if (hub_oe_n !== 1'b0 || hub_clk !== 1'b1 || pix_line !== 5'd2) begin
      errors++;
      $display("FAIL pre_reset_state got oe %b clk %b line %0d want 0 1 2", hub_oe_n, hub_clk, pix_line);
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if (snap() !== RST_VAL) begin
      errors++;
      $display("FAIL async_reset got %h want %h", snap(), RST_VAL);
    end
    repeat (3) @(negedge sys_clk);
    checks++;
    if (snap() !== RST_VAL) begin
      errors++;
      $display("FAIL reset_held got %h want %h", snap(), RST_VAL);
    end
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    checks++;
    if (pix_line !== 5'd0 || hub_oe_n !== 1'b1) begin
      errors++;
      $display("FAIL restart_after_reset got line %0d oe %b want 0 1", pix_line, hub_oe_n);
    end
    enable = 1'b0;
  endtask

`ifdef HUB75_OE_DIM_EN
  task automatic test_dim();
    int k = 0, ln = 0, on = 0, dline = 0, guard = 0, lim = 0;
    bit shown = 0;
    logic [2:0] dseq [6];
    logic exp_oe;
    dseq[0] = 3'd4;
    dseq[1] = 3'd0;
    dseq[2] = 3'd7;
    dseq[3] = 3'($urandom_range(0, 7));
    dseq[4] = 3'($urandom_range(0, 7));
    dseq[5] = 3'($urandom_range(0, 7));
    pat_mode = 1;
    dim = 3'd4;
    do_reset();
    enable = 1'b1;
    while (ln < 6 && guard < 8 * L) begin
      @(negedge sys_clk);
      guard++;
      if (k == 10) dim = dseq[ln];
      lim = (64 - 8 * dline) * 2 * CD;
      exp_oe = (shown && k < SHIFT_CYC && k < lim) ? 1'b0 : 1'b1;
      checks++;
      if (hub_oe_n !== exp_oe) begin
        errors++;
        $display("FAIL dim_oe line %0d dim %0d pos %0d got %b want %b", ln, dline, k, hub_oe_n, exp_oe);
      end
      if (hub_oe_n === 1'b0) on++;
      if (k == L - 1) begin
        if (shown) begin
          checks++;
          if (on != lim) begin
            errors++;
            $display("FAIL dim_on_cycles line %0d got %0d want %0d", ln, on, lim);
          end
        end
        shown = 1;
        dline = int'(dseq[ln]);
        on = 0;
        ln++;
        k = 0;
      end else begin
        k++;
      end
    end
    checks++;
    if (ln < 6) begin
      errors++;
      $display("FAIL dim_timeout got %0d lines want 6", ln);
    end
    enable = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 6'($urandom);
    test_reset();
    test_pattern();
    test_frame();
    test_enable_drop();
    test_async_reset();
`ifdef HUB75_OE_DIM_EN
    test_dim();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
